prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/attrs.sv | 22 ++
 rtl/prog_loader.sv | 243 ++++++++++++++++++++++++
 tb/tb_prog_loader.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/attrs.sv
// Shared attributes for the program ROM and its serial loader: instruction
// word geometry, ROM depth and the loader state encoding.
package attrs;

  localparam int IR_WIDTH  = 32;
  localparam int ROM_DEPTH = 256;
  localparam int IR_BYTES  = (IR_WIDTH + 7) / 8;

  typedef logic [IR_WIDTH-1:0] ir_word_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_ENTER,
    S_ASM,
    S_AVAIL,
    S_RELEASE,
    S_CKSUM,
    S_FINISH
  } loader_state_t;

endpackage

// File: rtl/prog_loader.sv
// Program loader: receives a byte stream (16-bit LSB-first word count, then
// LSB-first instruction words) and writes it into the program ROM over the
// prog / p_avail / p_ready / p_lo_ack handshake, keeping the cores in reset
// (prog high) for the whole load.
// Optional feature macro PROG_LOADER_CKSUM_EN: a trailing XOR checksum byte
// is verified; on mismatch prog is held high until reset or a new load.
module prog_loader
  import attrs::*;
#(
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                src_valid,
  input  logic [7:0]          src_data,
  output logic                src_ready,
  output logic                prog,
  output logic                p_avail,
  output logic [IR_WIDTH-1:0] p_d_in,
  input  logic                p_ready,
  input  logic                p_lo_ack,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);
  localparam int ASM_W  = IR_BYTES * 8;
  localparam int BIDX_W = (IR_BYTES > 1) ? $clog2(IR_BYTES) : 1;
  localparam logic [15:0]       MAX_N     = 16'(ROM_DEPTH);
  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(IR_BYTES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  loader_state_t     state_q, state_d;
  logic [15:0]       rem_q, rem_d;
  logic [BIDX_W-1:0] bidx_q, bidx_d;
  logic [ASM_W-1:0]  asm_q, asm_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef PROG_LOADER_CKSUM_EN
  logic [7:0]        cks_q, cks_d;
  logic              hold_q, hold_d;
`endif

  logic              accept;
  logic              timeout;
  logic [15:0]       hdr_n;
  logic [ASM_W+7:0]  shift_w;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      bidx_q  <= '0;
      asm_q   <= '0;
      wait_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef PROG_LOADER_CKSUM_EN
      cks_q   <= '0;
      hold_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      bidx_q  <= bidx_d;
      asm_q   <= asm_d;
      wait_q  <= wait_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef PROG_LOADER_CKSUM_EN
      cks_q   <= cks_d;
      hold_q  <= hold_d;
`endif
    end
  end

  // Next-state and datapath update logic
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    bidx_d  = bidx_q;
    asm_d   = asm_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef PROG_LOADER_CKSUM_EN
    cks_d   = cks_q;
    hold_d  = hold_q;
`endif
    accept  = src_valid && src_ready;
    timeout = (wait_q == WAIT_LAST);
    hdr_n   = {src_data, rem_q[7:0]};
    shift_w = {src_data, asm_q};

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          rem_d   = {8'h00, src_data};
          state_d = S_HDR;
`ifdef PROG_LOADER_CKSUM_EN
          cks_d   = src_data;
`endif
        end
      end
      S_HDR: begin
        if (accept) begin
          rem_d = hdr_n;
`ifdef PROG_LOADER_CKSUM_EN
          cks_d = cks_q ^ src_data;
`endif
          if (hdr_n == 16'd0) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
`ifdef PROG_LOADER_CKSUM_EN
            hold_d  = 1'b0;
`endif
          end else if (hdr_n > MAX_N) begin
            // Oversized program: reject before touching the ROM.
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_ENTER;
`ifdef PROG_LOADER_CKSUM_EN
            hold_d  = 1'b0;
`endif
          end
        end
      end
      S_ENTER: begin
        if (p_lo_ack) begin
          bidx_d  = '0;
          state_d = S_ASM;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ASM: begin
        if (accept) begin
          asm_d = shift_w[ASM_W+7:8];
`ifdef PROG_LOADER_CKSUM_EN
          cks_d = cks_q ^ src_data;
`endif
          if (bidx_q == LAST_BYTE) begin
            bidx_d  = '0;
            state_d = S_AVAIL;
          end else begin
            bidx_d  = bidx_q + BIDX_W'(1);
          end
        end
      end
      S_AVAIL: begin
        if (p_ready) begin
          state_d = S_RELEASE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RELEASE: begin
        if (p_lo_ack) begin
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
`ifdef PROG_LOADER_CKSUM_EN
            state_d = S_CKSUM;
`else
            state_d = S_FINISH;
`endif
          end else begin
            state_d = S_ASM;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
`ifdef PROG_LOADER_CKSUM_EN
      S_CKSUM: begin
        if (accept) begin
          if (src_data == cks_q) begin
            state_d = S_FINISH;
          end else begin
            // Corrupt image in ROM: keep the cores parked in reset.
            err_d   = 1'b1;
            hold_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
`endif
      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Handshake wait counter restarts whenever the state changes.
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (state_q == S_ENTER || state_q == S_AVAIL || state_q == S_RELEASE) begin
      wait_d = wait_q + WAIT_W'(1);
    end else begin
      wait_d = '0;
    end
  end

  // Moore outputs decoded from the current state
  always_comb begin
    src_ready = 1'b0;
    prog      = 1'b0;
    p_avail   = 1'b0;
    busy      = (state_q != S_IDLE);
    case (state_q)
      S_IDLE, S_HDR: src_ready = !rst;
      S_ENTER:       prog = 1'b1;
      S_ASM: begin
        src_ready = !rst;
        prog      = 1'b1;
      end
      S_AVAIL: begin
        prog    = 1'b1;
        p_avail = 1'b1;
      end
      S_RELEASE:     prog = 1'b1;
      S_CKSUM: begin
        src_ready = !rst;
        prog      = 1'b1;
      end
      default: ;
    endcase
`ifdef PROG_LOADER_CKSUM_EN
    if (hold_q) prog = 1'b1;
`endif
  end

  assign p_d_in = asm_q[IR_WIDTH-1:0];
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a small behavioural program ROM.
module tb_prog_loader;
  import attrs::*;

  localparam int TMO = 16;

  typedef logic [7:0] bq_t[$];

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                src_valid = 1'b0;
  logic [7:0]          src_data = 8'h00;
  logic                src_ready;
  logic                prog;
  logic                p_avail;
  logic [IR_WIDTH-1:0] p_d_in;
  logic                p_ready = 1'b0;
  logic                p_lo_ack = 1'b1;
  logic                busy;
  logic                done;
  logic                err;

  int n_cmp = 0;
  int n_bad = 0;

  int done_cnt = 0;
  int err_cnt = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;
  logic prog_prev = 1'b0;

  logic [31:0] rom_mem [0:255];
  logic [7:0]  rom_addr = 8'h00;
  logic        rom_stall = 1'b0;

  prog_loader #(.ACK_TIMEOUT(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .src_valid(src_valid),
    .src_data (src_data),
    .src_ready(src_ready),
    .prog     (prog),
    .p_avail  (p_avail),
    .p_d_in   (p_d_in),
    .p_ready  (p_ready),
    .p_lo_ack (p_lo_ack),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Program ROM model: commit on p_avail, then go idle once p_avail drops.
  always @(posedge clk) begin
    if (rst) begin
      p_ready  <= 1'b0;
      p_lo_ack <= 1'b1;
      rom_addr <= 8'h00;
    end else begin
      if (!prog) rom_addr <= 8'h00;
      if (p_avail && p_lo_ack && !p_ready && !rom_stall) begin
        rom_mem[rom_addr] <= p_d_in;
        p_ready  <= 1'b1;
        p_lo_ack <= 1'b0;
      end else if (p_ready && !p_avail) begin
        p_ready  <= 1'b0;
        p_lo_ack <= 1'b1;
        rom_addr <= rom_addr + 8'd1;
      end
    end
  end

  // Event monitor
  always @(posedge clk) begin
    prog_prev <= prog;
    if (done) done_cnt <= done_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
    if (prog && !prog_prev) rise_cnt <= rise_cnt + 1;
    if (!prog && prog_prev) fall_cnt <= fall_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    src_valid = 1'b1;
    src_data  = b;
    while (!src_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("src_ready_wait", 32'(src_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    src_valid = 1'b0;
  endtask

  task automatic send_list(input bq_t s);
    foreach (s[i]) send_byte(s[i]);
  endtask

  function automatic logic [7:0] xor_of(input bq_t s);
    logic [7:0] x;
    x = 8'h00;
    foreach (s[i]) x = x ^ s[i];
    return x;
  endfunction

  task automatic wait_evt(input string tag, input int d0, input int e0);
    int n;
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'((done_cnt != d0) || (err_cnt != e0)), 32'd1);
  endtask

  initial begin
    bq_t s;
    int d0, e0, r0, f0, k;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_src_ready", 32'(src_ready), 32'd0);
    chk("rst_prog",      32'(prog),      32'd0);
    chk("rst_p_avail",   32'(p_avail),   32'd0);
    chk("rst_p_d_in",    p_d_in,         32'h0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_done_err",  32'({done, err}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_src_ready", 32'(src_ready), 32'd1);

    // Two-word load
    d0 = done_cnt; e0 = err_cnt; r0 = rise_cnt; f0 = fall_cnt;
    s = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef PROG_LOADER_CKSUM_EN
    s.push_back(8'h28);
`endif
    send_list(s);
    wait_evt("load2_evt", d0, e0);
    repeat (2) @(negedge clk);
    chk("load2_rom0",  rom_mem[0], 32'h12345678);
    chk("load2_rom1",  rom_mem[1], 32'hDEADBEEF);
    chk("load2_rise",  32'(rise_cnt - r0), 32'd1);
    chk("load2_fall",  32'(fall_cnt - f0), 32'd1);
    chk("load2_done",  32'(done_cnt - d0), 32'd1);
    chk("load2_err",   32'(err_cnt - e0),  32'd0);
    chk("load2_prog",  32'(prog), 32'd0);
    chk("load2_busy",  32'(busy), 32'd0);

    // Empty program
    d0 = done_cnt; e0 = err_cnt; r0 = rise_cnt;
    send_list('{8'h00, 8'h00});
    wait_evt("n0_evt", d0, e0);
    @(negedge clk);
    chk("n0_done", 32'(done_cnt - d0), 32'd1);
    chk("n0_rise", 32'(rise_cnt - r0), 32'd0);
    chk("n0_busy", 32'(busy), 32'd0);

    // Oversized program (N=257)
    d0 = done_cnt; e0 = err_cnt; r0 = rise_cnt;
    send_list('{8'h01, 8'h01});
    wait_evt("big_evt", d0, e0);
    @(negedge clk);
    chk("big_err",   32'(err_cnt - e0),  32'd1);
    chk("big_done",  32'(done_cnt - d0), 32'd0);
    chk("big_rise",  32'(rise_cnt - r0), 32'd0);
    chk("big_idle",  32'({busy, src_ready}), 32'b01);

    // ROM never commits: p_ready timeout
    rom_stall = 1'b1;
    e0 = err_cnt;
    send_list('{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD});
    k = 0;
    while (!p_avail && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("tmo_avail", 32'(p_avail), 32'd1);
    chk("tmo_word",  p_d_in, 32'hDDCCBBAA);
    k = 0;
    while (!err && k < 3 * TMO) begin
      @(negedge clk);
      k++;
    end
    chk("tmo_cycles",  32'(k), 32'(TMO));
    chk("tmo_prog",    32'(prog), 32'd0);
    chk("tmo_p_avail", 32'(p_avail), 32'd0);
    rom_stall = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of the second word, then a fresh load
    send_list('{8'h02, 8'h00, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22});
    chk("mid_prog_before", 32'(prog), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_prog", 32'(prog), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    d0 = done_cnt; e0 = err_cnt;
    s = '{8'h01, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01};
`ifdef PROG_LOADER_CKSUM_EN
    s.push_back(xor_of(s));
`endif
    send_list(s);
    wait_evt("fresh_evt", d0, e0);
    @(negedge clk);
    chk("fresh_rom0", rom_mem[0], 32'h01020304);
    chk("fresh_done", 32'(done_cnt - d0), 32'd1);
    chk("fresh_prog", 32'(prog), 32'd0);

`ifdef PROG_LOADER_CKSUM_EN
    // Checksum match and mismatch
    d0 = done_cnt; e0 = err_cnt;
    send_list('{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45});
    wait_evt("ck_ok_evt", d0, e0);
    @(negedge clk);
    chk("ck_ok_done", 32'(done_cnt - d0), 32'd1);
    chk("ck_ok_rom0", rom_mem[0], 32'h44332211);
    d0 = done_cnt; e0 = err_cnt;
    send_list('{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00});
    wait_evt("ck_bad_evt", d0, e0);
    repeat (4) @(negedge clk);
    chk("ck_bad_err",  32'(err_cnt - e0), 32'd1);
    chk("ck_bad_prog", 32'(prog), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("ck_rst_prog", 32'(prog), 32'd0);
`else
    chk("xor_helper", 32'(xor_of('{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44})), 32'h45);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
